// File: rtl/hc161_seq_ctrl.sv
// rtl/hc161_seq_ctrl.sv - load/check/count sequencer for an external HC161 counter
// Optional stall watchdog enabled by defining HC161_SEQ_WATCHDOG_EN.
module hc161_seq_ctrl (
  input  logic       CP,
  input  logic       MR,
  input  logic       REQ,
  input  logic [3:0] PRESET,
  input  logic [3:0] TERM,
  input  logic       AUTO,
  input  logic       HOLD,
  input  logic       STOP,
  input  logic [3:0] Qn,
  output logic [3:0] Dn,
  output logic       PEN,
  output logic       CEP,
  output logic       CET,
  output logic       ACK,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_COUNT = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0] state;
  logic [3:0] preset_q;
  logic [3:0] term_q;
  logic       auto_q;
  logic       cnt_en;
  logic       stall_trip;

  // Enables drop combinationally on TERM so the counter parks exactly there.
  assign cnt_en = (state == S_COUNT) && !HOLD && (Qn != term_q);
  assign CEP    = cnt_en;
  assign CET    = cnt_en;
  assign PEN    = (state != S_LOAD);
  assign BUSY   = (state != S_IDLE);
  assign DONE   = (state == S_FIN);
  assign Dn     = preset_q;

`ifdef HC161_SEQ_WATCHDOG_EN
  logic [1:0] stall;
  logic [3:0] qn_prev;

  always_ff @(posedge CP) begin
    if (MR) begin
      stall   <= 2'd0;
      qn_prev <= 4'd0;
    end else begin
      qn_prev <= Qn;
      if (cnt_en && (Qn == qn_prev)) begin
        if (stall != 2'd3) stall <= stall + 2'd1;
      end else begin
        stall <= 2'd0;
      end
    end
  end

  assign stall_trip = (stall == 2'd3);
`else
  assign stall_trip = 1'b0;
`endif

  always_ff @(posedge CP) begin
    if (MR) begin
      state    <= S_IDLE;
      preset_q <= 4'd0;
      term_q   <= 4'd0;
      auto_q   <= 1'b0;
      ACK      <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ACK <= 1'b0;
      if (STOP && (state != S_IDLE)) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (REQ) begin
              preset_q <= PRESET;
              term_q   <= TERM;
              auto_q   <= AUTO;
              ACK      <= 1'b1;
              ERR      <= 1'b0;
              state    <= S_LOAD;
            end
          end
          S_LOAD: state <= S_CHECK;
          S_CHECK: begin
            // A counter that did not take the load is a datapath fault.
            if (Qn == preset_q) begin
              state <= (preset_q == term_q) ? S_FIN : S_COUNT;
            end else begin
              ERR   <= 1'b1;
              state <= S_IDLE;
            end
          end
          S_COUNT: begin
            if (stall_trip) begin
              ERR   <= 1'b1;
              state <= S_IDLE;
            end else if (Qn == term_q) begin
              state <= S_FIN;
            end
          end
          S_FIN:   state <= auto_q ? S_LOAD : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hc161_seq_ctrl.sv
// tb/tb_hc161_seq_ctrl.sv - randomized and directed bench for hc161_seq_ctrl
module tb_hc161_seq_ctrl;

  logic       CP = 1'b0;
  logic       MR, REQ, AUTO, HOLD, STOP;
  logic [3:0] PRESET, TERM, Qn, Dn;
  logic       PEN, CEP, CET, ACK, BUSY, DONE, ERR;

  int tests = 0;
  int fails = 0;

  logic       stuck  = 1'b0;
  logic       freeze = 1'b0;
  logic       chk_en = 1'b0;
  logic [3:0] cq     = 4'd0;

  hc161_seq_ctrl dut (
    .CP(CP), .MR(MR), .REQ(REQ), .PRESET(PRESET), .TERM(TERM), .AUTO(AUTO),
    .HOLD(HOLD), .STOP(STOP), .Qn(Qn), .Dn(Dn), .PEN(PEN), .CEP(CEP), .CET(CET),
    .ACK(ACK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CP = ~CP;

  // HC161 stand-in; stuck pins it at 9, freeze ignores count enables
  always @(posedge CP) begin
    if (stuck)                       cq <= 4'd9;
    else if (!PEN)                   cq <= Dn;
    else if (CEP && CET && !freeze)  cq <= cq + 4'd1;
  end
  assign Qn = cq;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: phase plus number of increments still owed to reach TERM
  int         m_ph;   // 0 idle, 1 load, 2 check, 3 count, 4 fin
  int         m_rem;
  logic [3:0] m_pre, m_term, m_dn;
  logic       m_auto, m_err, m_ack;

  always @(posedge CP) begin
    if (MR) begin
      m_ph = 0; m_rem = 0; m_pre = 0; m_term = 0; m_dn = 0;
      m_auto = 0; m_err = 0; m_ack = 0;
    end else begin
      m_ack = 0;
      if (STOP && m_ph != 0) m_ph = 0;
      else begin
        case (m_ph)
          0: if (REQ) begin
               m_pre = PRESET; m_term = TERM; m_auto = AUTO; m_dn = PRESET;
               m_ack = 1; m_err = 0; m_ph = 1;
             end
          1: begin
               m_rem = (int'(m_term) - int'(m_pre) + 16) % 16;
               m_ph  = 2;
             end
          2: if (stuck && m_pre != 4'd9) begin m_err = 1; m_ph = 0; end
             else m_ph = (m_rem == 0) ? 4 : 3;
          3: if (m_rem == 0) m_ph = 4;
             else if (!HOLD) m_rem = m_rem - 1;
          4: m_ph = m_auto ? 1 : 0;
          default: m_ph = 0;
        endcase
      end
    end
  end

  always @(negedge CP) begin
    if (chk_en) begin
      logic       exp_cnt;
      logic [3:0] exp_q;
      exp_cnt = (m_ph == 3) && !HOLD && (m_rem != 0);
      exp_q   = m_term - 4'(m_rem);
      check("busy", BUSY, m_ph != 0);
      check("pen",  PEN,  m_ph != 1);
      check("cep",  CEP,  exp_cnt);
      check("cet",  CET,  exp_cnt);
      check("done", DONE, m_ph == 4);
      check("ack",  ACK,  m_ack);
      check("err",  ERR,  m_err);
      check("dn",   Dn,   m_dn);
      if ((m_ph == 3 || m_ph == 4) && !stuck) check("qn", Qn, exp_q);
    end
  end

  // Event log used by the directed scenarios
  int         cyc = 0, cnt_cep = 0, cnt_done = 0, cnt_ack = 0, cnt_pen = 0;
  int         ack_cyc = 0, done_cyc = -1, done_gap = 0;
  logic [3:0] qlog[$];

  always @(negedge CP) begin
    cyc++;
    if (CEP) begin cnt_cep++; qlog.push_back(Qn); end
    if (!PEN) cnt_pen++;
    if (ACK) begin cnt_ack++; ack_cyc = cyc; end
    if (DONE) begin
      if (done_cyc >= 0) done_gap = cyc - done_cyc;
      done_cyc = cyc;
      cnt_done++;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) begin @(posedge CP); #1; end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (BUSY && n < bound) begin cyc_n(1); n++; end
    if (BUSY) check("wait_idle_timeout", 1, 0);
  endtask

  task automatic start(input logic [3:0] p, input logic [3:0] t, input logic a);
    PRESET = p; TERM = t; AUTO = a; REQ = 1'b1;
    cyc_n(1);
    REQ = 1'b0; AUTO = 1'b0;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, BUSY, 0);
    check({nm, "_ack"},  ACK,  0);
    check({nm, "_done"}, DONE, 0);
    check({nm, "_err"},  ERR,  0);
    check({nm, "_pen"},  PEN,  1);
    check({nm, "_cep"},  CEP,  0);
    check({nm, "_cet"},  CET,  0);
    check({nm, "_dn"},   Dn,   0);
  endtask

  initial begin
    int b_cep, b_done, b_ack, b_pen, b_q, n;
    logic [3:0] wrap_exp[5];
    wrap_exp = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};

    MR = 1; REQ = 0; PRESET = 0; TERM = 0; AUTO = 0; HOLD = 0; STOP = 0;
    cyc_n(2);
    check_reset_outputs("reset");
    MR = 0; chk_en = 1;
    cyc_n(1);

    // 3 -> 7 single shot
    b_cep = cnt_cep; b_done = cnt_done; b_pen = cnt_pen;
    start(3, 7, 0);
    check("s1_ack", ACK, 1);
    check("s1_pen", PEN, 0);
    wait_idle(30);
    check("s1_cep_cycles", cnt_cep - b_cep, 4);
    check("s1_pen_cycles", cnt_pen - b_pen, 1);
    check("s1_done_count", cnt_done - b_done, 1);
    check("s1_qn_final", Qn, 7);
    check("s1_ack_to_done", done_cyc - ack_cyc, 7);

    // wrap 13 -> 2
    b_cep = cnt_cep; b_done = cnt_done; b_q = qlog.size();
    start(13, 2, 0);
    wait_idle(40);
    check("wrap_cep_cycles", cnt_cep - b_cep, 5);
    for (int i = 0; i < 5; i++)
      if (b_q + i < qlog.size()) check("wrap_qn_seq", qlog[b_q + i], wrap_exp[i]);
    check("wrap_qn_final", Qn, 2);
    check("wrap_done_count", cnt_done - b_done, 1);

    // PRESET == TERM
    b_cep = cnt_cep; b_done = cnt_done;
    start(5, 5, 0);
    wait_idle(20);
    check("eq_cep_cycles", cnt_cep - b_cep, 0);
    check("eq_done_count", cnt_done - b_done, 1);

    // HOLD three cycles mid count
    b_cep = cnt_cep;
    start(3, 7, 0);
    cyc_n(3);
    HOLD = 1;
    check("hold_qn_start", Qn, 4);
    cyc_n(3);
    HOLD = 0;
    check("hold_qn_frozen", Qn, 4);
    wait_idle(30);
    check("hold_cep_cycles", cnt_cep - b_cep, 4);
    check("hold_ack_to_done", done_cyc - ack_cyc, 10);

    // counter ignores the load
    stuck = 1;
    cyc_n(1);
    b_done = cnt_done;
    start(4, 4, 0);
    wait_idle(20);
    check("load_fault_err", ERR, 1);
    check("load_fault_done", cnt_done - b_done, 0);
    stuck = 0;
    start(6, 6, 0);
    check("err_cleared", ERR, 0);
    wait_idle(20);

    // auto repeat, then STOP mid count
    b_done = cnt_done;
    start(0, 2, 1);
    n = 0;
    while (cnt_done - b_done < 2 && n < 40) begin cyc_n(1); n++; end
    check("auto_two_dones", (cnt_done - b_done) >= 2, 1);
    check("auto_period", done_gap, 6);
    cyc_n(3);
    check("auto_qn_mid", Qn, 1);
    STOP = 1;
    b_done = cnt_done;
    cyc_n(1);
    STOP = 0;
    check("stop_busy", BUSY, 0);
    cyc_n(3);
    check("stop_no_done", cnt_done - b_done, 0);

    // REQ held through FIN is taken in the next idle cycle
    b_ack = cnt_ack;
    PRESET = 1; TERM = 1; REQ = 1;
    cyc_n(6);
    REQ = 0;
    check("req_held_acks", cnt_ack - b_ack, 2);
    wait_idle(20);

    // reset mid count
    start(0, 15, 0);
    cyc_n(4);
    MR = 1; STOP = 1; REQ = 1;
    cyc_n(1);
    check_reset_outputs("mr_mid");
    MR = 0; STOP = 0; REQ = 0;
    cyc_n(1);

`ifdef HC161_SEQ_WATCHDOG_EN
    chk_en = 0; freeze = 1;
    b_done = cnt_done;
    start(2, 9, 0);
    wait_idle(20);
    check("wd_err", ERR, 1);
    check("wd_no_done", cnt_done - b_done, 0);
    freeze = 0; MR = 1;
    cyc_n(1);
    MR = 0; chk_en = 1;
`endif

    for (int i = 0; i < 3000; i++) begin
      REQ    = ($urandom % 4) == 0;
      PRESET = 4'($urandom);
      TERM   = 4'($urandom);
      AUTO   = ($urandom % 3) == 0;
      HOLD   = ($urandom % 6) == 0;
      STOP   = ($urandom % 40) == 0;
      MR     = ($urandom % 200) == 0;
      cyc_n(1);
    end
    REQ = 0; HOLD = 0; STOP = 0; MR = 0;
    cyc_n(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hc161_seq_ctrl.md
HC161_SEQ_CTRL -- requirements
Module: hc161_seq_ctrl

Interface
REQ-001 The block SHALL have one clock, CP, and a synchronous, active-high reset, MR; all state changes occur on the rising edge of CP.
REQ-002 CP  in  1  clock.
REQ-003 MR  in  1  synchronous active-high reset.
REQ-004 REQ  in  1  start request, level-sampled.
REQ-005 PRESET  in  4  counter load value, captured on accept.
REQ-006 TERM  in  4  stop value, captured on accept.
REQ-007 AUTO  in  1  reload-and-repeat mode, captured on accept.
REQ-008 HOLD  in  1  pause counting while high.
REQ-009 STOP  in  1  abort the active sequence.
REQ-010 Qn  in  4  counter value read back from the HC161 datapath.
REQ-011 Dn  out  4  load data to the counter.
REQ-012 PEN  out  1  active-low parallel load to the counter.
REQ-013 CEP, CET  out  1 each  count enables to the counter.
REQ-014 ACK  out  1  one-cycle request-accepted pulse.
REQ-015 BUSY  out  1  sequence active.
REQ-016 DONE  out  1  one-cycle sequence-complete pulse.
REQ-017 ERR  out  1  sticky fault flag.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, CHECK, COUNT and FIN.
REQ-019 IDLE: when REQ=1, the block SHALL latch PRESET, TERM and AUTO, pulse ACK for one cycle, clear ERR, and enter LOAD on the next edge.
REQ-020 LOAD: the block SHALL drive PEN=0 and Dn=latched PRESET for exactly one cycle, then enter CHECK.
REQ-021 CHECK: the block SHALL drive PEN=1; if Qn equals PRESET, it SHALL enter FIN when PRESET equals TERM and COUNT otherwise; if Qn differs from PRESET, it SHALL set ERR and enter IDLE without a DONE pulse.
REQ-022 COUNT: CEP and CET SHALL be combinational and equal (state==COUNT) AND !HOLD AND (Qn != TERM), so the counter stops exactly on TERM.
REQ-023 COUNT: the block SHALL enter FIN in the cycle after Qn==TERM is observed.
REQ-024 Wrap-around: a TERM value below PRESET SHALL count through 15 to 0 without special handling (for example, PRESET=13, TERM=2 gives 5 increments).
REQ-025 FIN: the block SHALL pulse DONE for one cycle, then enter LOAD if AUTO=1 and IDLE otherwise.
REQ-026 BUSY SHALL be 1 in every state except IDLE.
REQ-027 REQ SHALL be ignored, with no ACK, while BUSY=1; a request held through FIN with AUTO=0 SHALL be accepted in the following IDLE cycle.
REQ-028 STOP=1 in any busy state SHALL return the block to IDLE on the next edge; no DONE pulse SHALL be issued, and STOP SHALL take priority over all other transitions.
REQ-029 Dn SHALL hold the latched PRESET at all times after the first accept.
REQ-030 PEN SHALL be 1 outside the LOAD state.
REQ-031 CEP and CET SHALL be 0 outside the COUNT state.

Reset
REQ-032 MR=1 SHALL force the following on the next CP edge: state=IDLE, BUSY=0, ACK=0, DONE=0, ERR=0, PEN=1, CEP=CET=0, Dn=0, latched registers=0, and the watchdog counter=0.
REQ-033 Reset SHALL override STOP and REQ, including mid-sequence; no DONE pulse SHALL be issued.

Configuration
REQ-034 The macro HC161_SEQ_WATCHDOG_EN, when defined, SHALL add a 2-bit stall counter that increments each COUNT cycle with CEP=1 in which Qn equals the previous cycle's Qn.
REQ-035 The stall counter SHALL clear whenever Qn changes or CEP=0.
REQ-036 When the stall counter reaches 3, the block SHALL set ERR and enter IDLE without a DONE pulse.
REQ-037 Without HC161_SEQ_WATCHDOG_EN, no stall logic SHALL exist, and ERR SHALL be set only by a CHECK mismatch.

Verification
REQ-038 PRESET=3, TERM=7, AUTO=0, REQ pulse -> ACK in cycle 1, PEN=0 for one cycle, 4 CEP-high cycles, Qn stops at 7, one DONE pulse, BUSY falls.
REQ-039 PRESET=13, TERM=2 -> Qn runs 13,14,15,0,1,2 and DONE follows; PRESET=TERM=5 -> DONE with zero CEP cycles.
REQ-040 AUTO=1, PRESET=0, TERM=2 -> DONE pulses repeat periodically with a reload between them; a STOP pulse mid-COUNT -> IDLE next cycle with no DONE.
REQ-041 HOLD=1 for 3 cycles mid-COUNT -> CEP=CET=0 throughout and Qn frozen; counting resumes afterwards and the DONE cycle shifts by 3.
REQ-042 Counter model ignores the load (Qn stays 9, PRESET=4) -> ERR=1 after CHECK and no DONE; the next REQ clears ERR.
REQ-043 With HC161_SEQ_WATCHDOG_EN defined, counter model frozen in COUNT -> ERR=1 after 3 stalled cycles and return to IDLE; MR asserted mid-COUNT -> all outputs at reset values on the next edge.
